// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
// Each grant sends a two-byte frame (command byte, then data byte) with a per-byte timeout.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_cmd,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 tx_has_data,
  output logic [7:0]           tx_data,
  input  logic                 tx_is_transmitting,
  input  logic                 tx_transmission_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_CMD, SEND_DAT, WAIT_DAT, FINISH
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] rr_ptr, winner, pick, ptr_after_winner;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cmd_q, data_q;
  logic [7:0]       cmd_arr  [NUM_REQ];
  logic [7:0]       data_arr [NUM_REQ];
  logic             waiting, timed_out, start;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx, sel;
    logic             found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      idx = sum[IDX_W-1:0];
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_arr[i]  = req_cmd[8*i +: 8];
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  assign pick             = rr_pick(req, rr_ptr);
  assign ptr_after_winner = (winner == IDX_LAST) ? '0 : winner + 1'b1;
  assign waiting          = (state == WAIT_CMD) || (state == WAIT_DAT);
  // A done arriving on the last allowed cycle still completes the byte.
  assign timed_out        = waiting && !tx_transmission_done && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_next  = state;
    busy        = (state != IDLE);
    tx_has_data = 1'b0;
    tx_data     = '0;
    done        = '0;
    timeout_err = timed_out;
    start       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != '0 && !tx_is_transmitting) begin
          state_next = SEND_CMD;
          start      = 1'b1;
        end
      end
      SEND_CMD: begin
        tx_has_data = 1'b1;
        tx_data     = cmd_q;
        state_next  = WAIT_CMD;
      end
      WAIT_CMD: begin
        tx_data = cmd_q;
        if (tx_transmission_done) state_next = SEND_DAT;
        else if (timed_out)       state_next = IDLE;
      end
      SEND_DAT: begin
        tx_has_data = 1'b1;
        tx_data     = data_q;
        state_next  = WAIT_DAT;
      end
      WAIT_DAT: begin
        tx_data = data_q;
        if (tx_transmission_done) state_next = FINISH;
        else if (timed_out)       state_next = IDLE;
      end
      FINISH: begin
        done       = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the latched byte registers are reset too, so tx_data is a clean 0 out of reset.
      rr_ptr <= '0;
      winner <= '0;
      grant  <= '0;
      cmd_q  <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      if (start) begin
        winner <= pick;
        grant  <= NUM_REQ'(1) << pick;
        cmd_q  <= cmd_arr[pick];
        data_q <= data_arr[pick];
      end
      if (state == SEND_CMD || state == SEND_DAT) cnt <= '0;
      else if (waiting && !timed_out)             cnt <= cnt + 1'b1;
      // Both frame completion and abort release the grant and move the pointer past the winner.
      if (state == FINISH || timed_out) begin
        grant  <= '0;
        rr_ptr <= ptr_after_winner;
      end
    end
  end

endmodule
